// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: 8b10b TX scheduler framing SKP ordered sets, DLLPs and TLPs into one symbol stream
// Ports: clk_i/rst_i clock and sync active-high reset; tlp_*/dllp_* byte sources with ready handshakes;
// tx_ready_i datapath advance; data_frame_* symbol with K/ordered-set/bypass flags; skp_overrun_o/underrun_o pulses.
module tx_link_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] tlp_data_i,
  input  logic                  tlp_valid_i,
  input  logic                  tlp_last_i,
  output logic                  tlp_ready_o,
  input  logic [DATA_WIDTH-1:0] dllp_data_i,
  input  logic                  dllp_valid_i,
  input  logic                  dllp_last_i,
  output logic                  dllp_ready_o,
  input  logic                  tx_ready_i,
  output logic [DATA_WIDTH-1:0] data_frame_o,
  output logic                  data_frame_valid_o,
  output logic                  is_special_k_o,
  output logic                  is_ordered_set_o,
  output logic                  bypass_scrambler_o,
  output logic                  skp_overrun_o,
  output logic                  underrun_o
);
  localparam int CW = $clog2(SKP_INTERVAL);
  localparam logic [DATA_WIDTH-1:0] K_STP = DATA_WIDTH'(8'hFB);
  localparam logic [DATA_WIDTH-1:0] K_SDP = DATA_WIDTH'(8'h5C);
  localparam logic [DATA_WIDTH-1:0] K_END = DATA_WIDTH'(8'hFD);
  localparam logic [DATA_WIDTH-1:0] K_EDB = DATA_WIDTH'(8'hFE);
  localparam logic [DATA_WIDTH-1:0] K_COM = DATA_WIDTH'(8'hBC);
  localparam logic [DATA_WIDTH-1:0] K_SKP = DATA_WIDTH'(8'h1C);
  typedef enum logic [2:0] {S_IDLE, S_SKP, S_DLLP, S_TLP, S_END, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic pend_q, pend_d, src_q, src_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic k_q, k_d, os_q, os_d, valid_q, valid_d, ovr_q, ovr_d, und_q, und_d;
  logic expire, cur_valid, cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  // src_q selects the packet source (1 = DLLP) for the data and drain phases
  assign expire    = cnt_q == CW'(SKP_INTERVAL - 1);
  assign cur_valid = src_q ? dllp_valid_i : tlp_valid_i;
  assign cur_last  = src_q ? dllp_last_i : tlp_last_i;
  assign cur_data  = src_q ? dllp_data_i : tlp_data_i;
  assign tlp_ready_o  = tx_ready_i & ~src_q & ((state_q == S_TLP & tlp_valid_i) | state_q == S_DRAIN);
  assign dllp_ready_o = tx_ready_i & src_q & ((state_q == S_DLLP & dllp_valid_i) | state_q == S_DRAIN);
  assign data_frame_o       = data_q;
  assign data_frame_valid_o = valid_q;
  assign is_special_k_o     = k_q;
  assign bypass_scrambler_o = k_q;
  assign is_ordered_set_o   = os_q;
  assign skp_overrun_o      = ovr_q;
  assign underrun_o         = und_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    src_d   = src_q;
    data_d  = data_q;
    k_d     = k_q;
    os_d    = os_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    und_d   = 1'b0;
    if (tx_ready_i) begin
      cnt_d   = expire ? '0 : cnt_q + CW'(1);
      ovr_d   = expire & pend_q;
      pend_d  = expire | pend_q;
      valid_d = 1'b1;
      data_d  = '0;
      k_d     = 1'b0;
      os_d    = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            {data_d, k_d, os_d} = {K_COM, 2'b11};
            pend_d  = expire;
            idx_d   = '0;
            state_d = S_SKP;
          end else if (dllp_valid_i) begin
            {data_d, k_d, src_d} = {K_SDP, 2'b11};
            state_d = S_DLLP;
          end else if (tlp_valid_i) begin
            {data_d, k_d, src_d} = {K_STP, 2'b10};
            state_d = S_TLP;
          end
        end
        S_SKP: begin
          {data_d, k_d, os_d} = {K_SKP, 2'b11};
          idx_d   = idx_q + 3'd1;
          state_d = idx_q == 3'(SKP_COUNT - 1) ? S_IDLE : S_SKP;
        end
        S_DLLP, S_TLP: begin
          if (cur_valid) begin
            data_d  = cur_data;
            state_d = cur_last ? S_END : state_q;
          end else begin
            {data_d, k_d} = {K_EDB, 1'b1};
            und_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
        S_END: begin
          {data_d, k_d} = {K_END, 1'b1};
          state_d = S_IDLE;
        end
        S_DRAIN: state_d = cur_valid & cur_last ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      src_q   <= 1'b0;
      data_q  <= '0;
      k_q     <= 1'b0;
      os_q    <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
      data_q  <= data_d;
      k_q     <= k_d;
      os_q    <= os_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      und_q   <= und_d;
    end
  end
endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: randomized bench comparing the scheduler against a symbol-queue reference model
module tb_tx_link_scheduler;
  localparam int SI = 1180;
  localparam int SC = 3;
  localparam logic [9:0] Y_COM = 10'h3BC, Y_SKP = 10'h31C, Y_STP = 10'h2FB, Y_SDP = 10'h25C;
  localparam logic [9:0] Y_END = 10'h2FD, Y_EDB = 10'h2FE;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tlp_data_i = '0, dllp_data_i = '0;
  logic tlp_valid_i = 1'b0, tlp_last_i = 1'b0, dllp_valid_i = 1'b0, dllp_last_i = 1'b0, tx_ready_i = 1'b0;
  logic tlp_ready_o, dllp_ready_o, data_frame_valid_o, is_special_k_o, is_ordered_set_o;
  logic bypass_scrambler_o, skp_overrun_o, underrun_o;
  logic [7:0] data_frame_o;
  tx_link_scheduler dut (
    .clk_i(clk), .rst_i(rst),
    .tlp_data_i(tlp_data_i), .tlp_valid_i(tlp_valid_i), .tlp_last_i(tlp_last_i), .tlp_ready_o(tlp_ready_o),
    .dllp_data_i(dllp_data_i), .dllp_valid_i(dllp_valid_i), .dllp_last_i(dllp_last_i), .dllp_ready_o(dllp_ready_o),
    .tx_ready_i(tx_ready_i), .data_frame_o(data_frame_o), .data_frame_valid_o(data_frame_valid_o),
    .is_special_k_o(is_special_k_o), .is_ordered_set_o(is_ordered_set_o),
    .bypass_scrambler_o(bypass_scrambler_o), .skp_overrun_o(skp_overrun_o), .underrun_o(underrun_o)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, ovr_seen = 0, und_seen = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [7:0] tq[$], dq[$];
  bit gen_en = 0, gap_en = 0;
  int rdy_pct = 100;
  // model: a queue of fixed symbols still owed (SKPs, END) plus a packet mode
  logic [9:0] oq[$];
  int mode = 0;
  bit msrc = 0, mpend = 0, mval = 0, movr = 0, mund = 0, er_t, er_d;
  int mcnt = 0;
  logic [9:0] msym = '0;
  task automatic drive();
    if (gen_en && tq.size() == 0 && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 24)) tq.push_back(8'($urandom));
    if (gen_en && dq.size() == 0 && $urandom_range(0, 7) == 0)
      repeat (6) dq.push_back(8'($urandom));
    tlp_valid_i  = tq.size() > 0 && !(gap_en && $urandom_range(0, 19) == 0);
    tlp_data_i   = tq.size() > 0 ? tq[0] : 8'h00;
    tlp_last_i   = tq.size() == 1;
    dllp_valid_i = dq.size() > 0 && !(gap_en && $urandom_range(0, 19) == 0);
    dllp_data_i  = dq.size() > 0 ? dq[0] : 8'h00;
    dllp_last_i  = dq.size() == 1;
    tx_ready_i   = $urandom_range(0, 99) < rdy_pct;
  endtask
  task automatic model_step();
    bit fire, com, v, l;
    logic [7:0] d;
    movr = 0;
    mund = 0;
    if (!tx_ready_i) return;
    mval = 1;
    fire = 0;
    com  = 0;
    v = msrc ? dllp_valid_i : tlp_valid_i;
    l = msrc ? dllp_last_i : tlp_last_i;
    d = msrc ? dllp_data_i : tlp_data_i;
    mcnt++;
    if (mcnt == SI) begin
      mcnt = 0;
      fire = 1;
    end
    if (oq.size() > 0) msym = oq.pop_front();
    else if (mode == 1) begin
      if (v) begin
        msym = {2'b00, d};
        if (l) begin
          oq.push_back(Y_END);
          mode = 0;
        end
      end else begin
        msym = Y_EDB;
        mund = 1;
        mode = 2;
      end
    end else if (mode == 2) begin
      msym = '0;
      if (v && l) mode = 0;
    end else if (mpend) begin
      msym = Y_COM;
      com = 1;
      repeat (SC) oq.push_back(Y_SKP);
    end else if (dllp_valid_i) begin
      msym = Y_SDP;
      mode = 1;
      msrc = 1;
    end else if (tlp_valid_i) begin
      msym = Y_STP;
      mode = 1;
      msrc = 0;
    end else msym = '0;
    movr  = fire && mpend;
    mpend = (mpend && !com) || fire;
  endtask
  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    er_t = tx_ready_i && !msrc && ((mode == 1 && tlp_valid_i) || mode == 2);
    er_d = tx_ready_i && msrc && ((mode == 1 && dllp_valid_i) || mode == 2);
    check("tlp_ready", tlp_ready_o, er_t);
    check("dllp_ready", dllp_ready_o, er_d);
    @(posedge clk);
    if (tlp_valid_i && er_t) void'(tq.pop_front());
    if (dllp_valid_i && er_d) void'(dq.pop_front());
    model_step();
    #1;
    check("symbol", {is_special_k_o, is_ordered_set_o, data_frame_o}, msym);
    check("bypass", bypass_scrambler_o, msym[9]);
    check("valid", data_frame_valid_o, mval);
    check("skp_overrun", skp_overrun_o, movr);
    check("underrun", underrun_o, mund);
    ovr_seen += int'(skp_overrun_o);
    und_seen += int'(underrun_o);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {data_frame_o, data_frame_valid_o, is_special_k_o, is_ordered_set_o,
                      bypass_scrambler_o, skp_overrun_o, underrun_o}, '0);
    check("rst_ready", {tlp_ready_o, dllp_ready_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (1200) cycle();
    gen_en  = 1;
    gap_en  = 1;
    rdy_pct = 85;
    repeat (6000) cycle();
    gen_en  = 0;
    gap_en  = 0;
    rdy_pct = 100;
    repeat (120) cycle();
    tq = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    repeat (12) cycle();
    repeat (2500) tq.push_back(8'($urandom));
    repeat (2600) cycle();
    check("overrun_seen", ovr_seen > 0, 1'b1);
    check("underrun_seen", und_seen > 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tx_link_scheduler.md
Name: tx_link_scheduler

Overview:
- Gen1/2 (8b10b) TX link-layer scheduler feeding the multi-lane scrambler/encoder/serializer datapath, one symbol per cycle.
- Arbitrates between a TLP byte stream, a DLLP byte stream and an internal SKP ordered-set timer.
- Wraps packets in framing K-symbols and emits logical idle when there is no work.
- Drives the datapath control flags: ordered-set, scrambler bypass and K-symbol.

Parameters:
- DATA_WIDTH, 8, symbol width in bits.
- SKP_INTERVAL, 1180, accepted output symbols between SKP ordered-set requests (legal range ≥ 8).
- SKP_COUNT, 3, number of SKP symbols following COM (legal range 1..5).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- tlp_data_i  in  DATA_WIDTH  TLP byte.
- tlp_valid_i  in  1  TLP byte valid.
- tlp_last_i  in  1  final TLP byte.
- tlp_ready_o  out  1  TLP byte accepted this cycle.
- dllp_data_i  in  DATA_WIDTH  DLLP byte.
- dllp_valid_i  in  1  DLLP byte valid.
- dllp_last_i  in  1  final DLLP byte.
- dllp_ready_o  out  1  DLLP byte accepted this cycle.
- tx_ready_i  in  1  datapath accepts a symbol this cycle.
- data_frame_o  out  DATA_WIDTH  symbol to datapath.
- data_frame_valid_o  out  1  symbol valid.
- is_special_k_o  out  1  symbol is a K-code.
- is_ordered_set_o  out  1  symbol belongs to an ordered set (no striping).
- bypass_scrambler_o  out  1  do not scramble this symbol.
- skp_overrun_o  out  1  one-cycle pulse: SKP interval elapsed while a SKP was already pending.
- underrun_o  out  1  one-cycle pulse: packet source gap detected.

Behaviour:
- Reset: all outputs 0, state IDLE, SKP counter 0, skp_pending 0.
- Outputs are registered. The FSM and output register advance only on cycles with tx_ready_i=1; otherwise everything holds.
- The symbol chosen in cycle N appears on the outputs in cycle N+1.
- After the first advancing cycle out of reset, data_frame_valid_o stays 1.
- K-codes: STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE, COM=0xBC, SKP=0x1C.
- Every K-symbol sets is_special_k_o=1 and bypass_scrambler_o=1.
- SKP ordered-set symbols additionally set is_ordered_set_o=1.
- Logical idle: 0x00, all flags 0.
- SKP timer: increments on each advancing cycle. On reaching SKP_INTERVAL-1 it wraps to 0 and sets skp_pending. If skp_pending is already set at that point, it pulses skp_overrun_o and skp_pending stays 1. skp_pending clears when COM is emitted.
- States and transitions:
  - IDLE: priority is skp_pending, then dllp_valid_i, then tlp_valid_i, then none.
    - skp_pending: emit COM, go to SKP.
    - dllp_valid_i: emit SDP, go to DLLP.
    - tlp_valid_i: emit STP, go to TLP.
    - none: emit idle, stay in IDLE.
  - SKP: emit SKP SKP_COUNT times, then return to IDLE.
  - DLLP / TLP: ready_o = tx_ready_i & valid_i. Pass the byte through as a D-symbol.
    - On the last byte, go to END.
    - If valid_i=0 on an advancing cycle: emit EDB, pulse underrun_o, go to DRAIN.
  - END: emit END, go to IDLE.
  - DRAIN: ready_o = tx_ready_i. Discard bytes and emit idle until an accepted byte has last=1, then go to IDLE.
- No preemption: a pending SKP waits until the packet's END/EDB. Minimum packet is 1 byte: STP, byte, END.
- Back-to-back packets: IDLE is re-entered for exactly one decision cycle, during which the next start symbol is emitted (no idle gap).
- ready_o is 0 for a source not in its data phase.
- Reset asserted mid-packet returns to IDLE immediately; the source is responsible for discarding its partial packet.
- Simultaneous skp_pending, DLLP and TLP requests: order is COM+SKPs, then the DLLP, then the TLP.

Test Plan:
- Reset, then tx_ready_i=1 and no requests → continuous 0x00, valid=1, all flags 0. At symbol 1180: 0xBC then 3×0x1C, with is_ordered_set_o=1 and is_special_k_o=1.
- TLP of 4 bytes A1..A4 → output 0xFB(K), A1..A4, 0xFD(K). tlp_ready_o high for exactly 4 cycles.
- DLLP (6 bytes) and TLP valid in the same IDLE cycle → full SDP…END DLLP sequence, immediately followed by STP…END TLP, no idle between.
- SKP timer expires during a 20-byte TLP → COM+SKP emitted immediately after END; counter keeps counting from the expiry point.
- tx_ready_i low for 5 cycles mid-TLP → outputs frozen, no ready, no byte lost or duplicated.
- tlp_valid_i drops after byte 2 of 5 → EDB emitted, underrun_o pulses once. Idle continues until byte 5 (last) is drained, then normal operation resumes.
